// File: rtl/rca_seq_adder_if.sv
// Operand/result handshake bundle for rca_seq_adder.
// The master side supplies operands and consumes results; the slave side is the adder.
interface rca_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple-carry slice per clock, LSB first,
// with the slice carry held in a register between cycles.
module rca_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module rca_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   rca_seq_adder_if.slave bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("rca_seq_adder: WIDTH must be a positive multiple of 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [IW-1:0]           idx;
   logic                    carry;
   logic [NSLICE-1:0][3:0]  a_reg, b_reg, sum_reg;
   logic                    cout_reg;
   logic [3:0]              s4;
   logic                    co4;
   logic                    last;

   assign last = (idx == IW'(NSLICE - 1));

   rca_4bit u_slice (
      .a  (a_reg[idx]),
      .b  (b_reg[idx]),
      .ci (carry),
      .s  (s4),
      .co (co4)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (bus.in_valid) begin
               a_reg <= bus.a;
               b_reg <= bus.b;
               carry <= bus.cin;
               idx   <= '0;
            end
            RUN: begin
               sum_reg[idx] <= s4;
               carry        <= co4;
               if (last) cout_reg <= co4;
               else      idx      <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs decode from state only, so valid/ready never see each other combinationally.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed and random checks of rca_seq_adder at WIDTH=16 and WIDTH=4.
module tb_rca_seq_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rca_seq_adder_if #(.WIDTH(16)) b16 ();
   rca_seq_adder_if #(.WIDTH(4))  b4  ();

   rca_seq_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   rca_seq_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Issue one add on the 16-bit DUT from IDLE; n = edges after accept until out_valid.
   task automatic add16(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output logic [15:0] s, output logic co, output int n);
      b16.a = x; b16.b = y; b16.cin = c; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
      tick();
      b16.in_valid = 1'b0;
      n = 0;
      while (n < 20 && !b16.out_valid) begin tick(); n++; end
      s = b16.sum; co = b16.cout;
      b16.out_ready = 1'b1;
      tick();
      b16.out_ready = 1'b0;
   endtask

   task automatic add4(input logic [3:0] x, input logic [3:0] y, input logic c,
                       output logic [3:0] s, output logic co, output int n);
      b4.a = x; b4.b = y; b4.cin = c; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
      tick();
      b4.in_valid = 1'b0;
      n = 0;
      while (n < 20 && !b4.out_valid) begin tick(); n++; end
      s = b4.sum; co = b4.cout;
      b4.out_ready = 1'b1;
      tick();
      b4.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({b16.in_ready, b16.out_valid, b16.busy, b16.sum, b16.cout} !== {3'b100, 16'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset16: rdy/vld/busy=%b%b%b sum=%h cout=%b, want 100 0000 0",
                  b16.in_ready, b16.out_valid, b16.busy, b16.sum, b16.cout);
      end
      checks++;
      if ({b4.in_ready, b4.out_valid, b4.busy, b4.sum, b4.cout} !== {3'b100, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset4: rdy/vld/busy=%b%b%b sum=%h cout=%b, want 100 0 0",
                  b4.in_ready, b4.out_valid, b4.busy, b4.sum, b4.cout);
      end
   endtask

   task automatic test_latency();
      int n;
      b16.a = 16'h0; b16.b = 16'h0; b16.cin = 1'b0; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
      tick();
      b16.in_valid = 1'b0;
      n = 0;
      while (n < 20 && !b16.out_valid) begin
         checks++;
         if (b16.busy !== 1'b1 || b16.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat_busy: busy=%b in_ready=%b at edge %0d, want 1 0", b16.busy, b16.in_ready, n);
         end
         tick(); n++;
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL lat16: out_valid after %0d edges, want 4", n); end
      checks++;
      if (b16.sum !== 16'h0 || b16.cout !== 1'b0 || b16.busy !== 1'b1) begin
         errors++;
         $display("FAIL zero16: sum=%h cout=%b busy=%b, want 0000 0 1", b16.sum, b16.cout, b16.busy);
      end
      b16.out_ready = 1'b1;
      tick();
      b16.out_ready = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0 || b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake16: vld=%b busy=%b rdy=%b, want 0 0 1", b16.out_valid, b16.busy, b16.in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] va [4] = '{16'hFFFF, 16'h8000, 16'h1234, 16'h0FFF};
      logic [15:0] vb [4] = '{16'h0001, 16'h8000, 16'h4321, 16'h0001};
      logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [16:0] ve [4] = '{17'h10000, 17'h10001, 17'h05556, 17'h01000};
      logic [15:0] s; logic co; int n;
      for (int i = 0; i < 4; i++) begin
         add16(va[i], vb[i], vc[i], s, co, n);
         checks++;
         if ({co, s} !== ve[i] || n != 4) begin
            errors++;
            $display("FAIL vec%0d: cout,sum=%h lat=%0d, want %h lat=4", i, {co, s}, n, ve[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      b16.a = 16'h1234; b16.b = 16'h4321; b16.cin = 1'b1; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
      tick();
      b16.in_valid = 1'b0;
      n = 0;
      while (n < 20 && !b16.out_valid) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin b16.a = 16'h1111; b16.b = 16'h1111; b16.in_valid = 1'b1; end
         else b16.in_valid = 1'b0;
         checks++;
         if (b16.out_valid !== 1'b1 || b16.in_ready !== 1'b0 || b16.sum !== 16'h5556 || b16.cout !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: vld=%b rdy=%b sum=%h cout=%b, want 1 0 5556 0",
                     i, b16.out_valid, b16.in_ready, b16.sum, b16.cout);
         end
         tick();
      end
      b16.in_valid = 1'b0;
      b16.out_ready = 1'b1;
      tick();
      b16.out_ready = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.busy !== 1'b0) begin
         errors++;
         $display("FAIL release: vld=%b rdy=%b busy=%b, want 0 1 0", b16.out_valid, b16.in_ready, b16.busy);
      end
   endtask

   task automatic test_reset_midrun();
      logic [15:0] s; logic co; int n;
      bit seen = 0;
      b16.a = 16'hFFFF; b16.b = 16'h0001; b16.cin = 1'b0; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
      tick();
      b16.in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.sum !== 16'h0 || b16.cout !== 1'b0) begin
         errors++;
         $display("FAIL midrst: vld=%b rdy=%b sum=%h cout=%b, want 0 1 0000 0",
                  b16.out_valid, b16.in_ready, b16.sum, b16.cout);
      end
      for (int i = 0; i < 6; i++) begin
         if (b16.out_valid) seen = 1;
         tick();
      end
      b16.out_ready = 1'b0;
      checks++;
      if (seen) begin errors++; $display("FAIL aborted: out_valid=1 seen after reset, want 0"); end
      add16(16'h0003, 16'h0004, 1'b0, s, co, n);
      checks++;
      if ({co, s} !== 17'h00007) begin
         errors++;
         $display("FAIL postrst: cout,sum=%h, want 00007", {co, s});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [3] = '{16'h0001, 16'hABCD, 16'hFFFF};
      logic [15:0] vb [3] = '{16'h0002, 16'h1111, 16'hFFFF};
      logic [16:0] ve [3] = '{17'h00003, 17'h0BCDE, 17'h1FFFE};
      int k = 0, cyc = 0, last_cyc = 0;
      b16.a = va[0]; b16.b = vb[0]; b16.cin = 1'b0; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
      while (k < 3 && cyc < 60) begin
         tick(); cyc++;
         if (b16.out_valid) begin
            checks++;
            if ({b16.cout, b16.sum} !== ve[k]) begin
               errors++;
               $display("FAIL b2b%0d: cout,sum=%h, want %h", k, {b16.cout, b16.sum}, ve[k]);
            end
            if (k > 0) begin
               checks++;
               if (cyc - last_cyc != 6) begin
                  errors++;
                  $display("FAIL b2b_gap%0d: %0d cycles, want 6", k, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            k++;
            if (k < 3) begin b16.a = va[k]; b16.b = vb[k]; end
            else b16.in_valid = 1'b0;
         end
      end
      checks++;
      if (k != 3) begin errors++; $display("FAIL b2b_timeout: %0d results, want 3", k); end
      tick(); tick();
      b16.out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] x, y, s; logic [3:0] x4, y4, s4; logic c, co; int n;
      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
         if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; c = 1'b1; end
         add16(x, y, c, s, co, n);
         checks++;
         if ({co, s} !== ({1'b0, x} + {1'b0, y} + 17'(c)) || n != 4) begin
            errors++;
            $display("FAIL rnd16: %h+%h+%b gave %h lat=%0d, want %h lat=4",
                     x, y, c, {co, s}, n, {1'b0, x} + {1'b0, y} + 17'(c));
         end
      end
      for (int i = 0; i < 1000; i++) begin
         x4 = 4'($urandom); y4 = 4'($urandom); c = 1'($urandom);
         if (i == 0) begin x4 = 4'hF; y4 = 4'hF; c = 1'b1; end
         add4(x4, y4, c, s4, co, n);
         checks++;
         if ({co, s4} !== ({1'b0, x4} + {1'b0, y4} + 5'(c)) || n != 1) begin
            errors++;
            $display("FAIL rnd4: %h+%h+%b gave %h lat=%0d, want %h lat=1",
                     x4, y4, c, {co, s4}, n, {1'b0, x4} + {1'b0, y4} + 5'(c));
         end
      end
   endtask

   initial begin
      b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0;
      b4.in_valid  = 1'b0; b4.out_ready  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0;
      tick(); tick();
      rst = 1'b0;
      test_reset();
      test_latency();
      test_vectors();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rca_seq_adder.md
Name: rca_seq_adder

Overview:
- Multi-cycle wide adder built around the existing 4-bit ripple-carry adder `rca_4bit`.
- Accepts WIDTH-bit operands through a valid/ready handshake and feeds one 4-bit slice per clock to a single `rca_4bit` instance, LSB slice first.
- Keeps the slice carry in a register between cycles.
- Presents the assembled sum and final carry downstream through a second valid/ready handshake.
- Trades latency for area when wide additions are needed.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails.
- NSLICE, WIDTH/4, number of 4-bit slices; derived (localparam), not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set a/b/cin is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- cin  input  1  carry-in to slice 0; sampled only on the accept edge.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result of a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; slice index, carry, operand registers, sum and cout clear to 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Reset has priority over every other event, including mid-RUN and during DONE. Any in-flight operation is aborted with no output produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge (in_valid & in_ready): latch a and b, carry <= cin, idx <= 0, go to RUN.
  - Without in_valid, stay in IDLE.
- RUN:
  - in_ready=0.
  - Each edge drives `rca_4bit` with A = a_reg[4*idx+:4], B = b_reg[4*idx+:4], carry_in = carry.
  - sum_reg[4*idx+:4] <= adder sum; carry <= adder carry_out.
  - If idx == NSLICE-1: cout <= carry_out and go to DONE. Otherwise idx <= idx+1.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1; sum and cout are stable and unchanged until the handshake.
  - Edge with out_ready=1: out_valid drops and the state returns to IDLE.
  - out_ready=0: hold indefinitely.
  - in_ready=0, so no new accept occurs in DONE.
- Latency: if operands are accepted at edge E0, the slices compute at E1..E(NSLICE). out_valid is high in the cycle after E(NSLICE).
- Minimum issue interval is NSLICE+2 cycles (accept, NSLICE slices, output handshake).
- sum is registered and updates slice by slice during RUN. It is meaningful only while out_valid=1.
- idx counter width is max(1, $clog2(NSLICE)).
- For WIDTH=4 (NSLICE=1), RUN lasts exactly one edge.
- Arithmetic: {cout, sum} == a + b + cin, exactly, for all inputs including all-ones wrap-around.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WIDTH=16, a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0; out_valid rises in the cycle after the 4th edge following accept; busy high from accept until the output handshake.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 slices). Also a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Then a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid stays 1, sum/cout unchanged, in_ready stays 0; an in_valid pulse with a=0x1111 is not accepted. Release out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst for 1 cycle after 2 slice edges of 0xFFFF+0x0001 -> next cycle out_valid=0, in_ready=1, sum=0, cout=0, and no result is emitted. A following 0x0003+0x0004, cin=0 gives sum=0x0007, cout=0.
- Back-to-back with out_ready tied high and in_valid high: each result completes 6 cycles apart. Add a random sweep of 1000 vectors checked against a + b + cin, for WIDTH=16 and WIDTH=4.
